// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: requester-side bus between the matrix-element sequencers and the multiplier arbiter
//   req_valid  [N_REQ]     per-requester operand valid
//   req_a/b    [N_REQ*32]  packed operands, requester i at [32i+31:32i]
//   req_ready  [N_REQ]     one-hot accept
//   rsp_valid  [N_REQ]     one-hot response pulse
//   rsp_id     [ID_W]      responding requester index
//   rsp_result [64]        unsigned product
//   rsp_err    [1]         watchdog expiry flag
interface mul_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_result;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined 32x32 multiplier between N_REQ requesters
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   bus        requester bus (slave side): requests in, one-hot ready, tagged response out
//   busy       high in every state except IDLE
//   mul_a/b    multiplier operands, stable while mul_do=1
//   mul_do     multiplier start/hold level
//   mul_result multiplier product
//   mul_done   multiplier completion
// Optional feature: MUL_WATCHDOG_EN adds a BUSY-cycle watchdog (parameter TIMEOUT)
// that ends the operation with rsp_err=1 and rsp_result=0.
module mul_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
`ifdef MUL_WATCHDOG_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    mul_share_arbiter_if.slave    bus,
    output logic                  busy,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    output logic                  mul_do,
    input  logic [63:0]           mul_result,
    input  logic                  mul_done
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt;
    logic [ID_W-1:0] gi;
    logic [ID_W:0]   c;
    logic            found;
    logic            wd;

`ifdef MUL_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    assign wd = (cnt == CW'(TIMEOUT - 1));
`else
    assign wd = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // first valid requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        gi    = '0;
        c     = '0;
        for (int j = 0; j < N_REQ; j++) begin
            c = {1'b0, ptr} + (ID_W + 1)'(j);
            if (c >= (ID_W + 1)'(N_REQ)) c = c - (ID_W + 1)'(N_REQ);
            if (!found && bus.req_valid[c[ID_W-1:0]]) begin
                found = 1'b1;
                gi    = c[ID_W-1:0];
            end
        end
    end

    assign bus.req_ready = (state == IDLE && found) ? N_REQ'(1) << gi : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ptr            <= '0;
            gnt            <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            mul_do         <= 1'b0;
            busy           <= 1'b0;
            bus.rsp_valid  <= '0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
`ifdef MUL_WATCHDOG_EN
            cnt            <= '0;
            bus.rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    mul_a  <= bus.req_a[32*gi +: 32];
                    mul_b  <= bus.req_b[32*gi +: 32];
                    gnt    <= gi;
                    mul_do <= 1'b1;
                    busy   <= 1'b1;
`ifdef MUL_WATCHDOG_EN
                    cnt    <= '0;
`endif
                    state  <= BUSY;
                end
                // mul_done takes precedence over a simultaneous watchdog expiry
                BUSY: if (mul_done || wd) begin
                    bus.rsp_valid  <= N_REQ'(1) << gnt;
                    bus.rsp_id     <= gnt;
                    bus.rsp_result <= mul_done ? mul_result : '0;
`ifdef MUL_WATCHDOG_EN
                    bus.rsp_err    <= !mul_done;
`endif
                    mul_do         <= 1'b0;
                    state          <= RESP;
                end
`ifdef MUL_WATCHDOG_EN
                else cnt <= cnt + 1'b1;
`endif
                RESP: begin
                    bus.rsp_valid <= '0;
`ifdef MUL_WATCHDOG_EN
                    bus.rsp_err   <= 1'b0;
`endif
                    busy          <= 1'b0;
                    ptr           <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for mul_share_arbiter with a latency-programmable multiplier model
module tb_mul_share_arbiter;
    localparam int TOUT = 8;

    logic        clk = 0;
    logic        reset = 0;
    logic        busy, mul_do, mul_done;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_result;

    logic [3:0]  valid = '0;
    logic [31:0] opa [4];
    logic [31:0] opb [4];

    int  lat = 3;
    bit  hold = 0;
    bit  spur = 0;
    bit  wd_exp = 0;
    bit  chk_dly = 1;
    int  mcnt = 0;
    int  cyc = 0;
    int  vectors = 0;
    int  errs = 0;

    typedef struct {int id; logic [63:0] res; logic err; int cyc; int dly; bit chk;} ent_t;
    typedef struct {logic [3:0] v; logic [1:0] id; logic [63:0] res; logic err; int cyc;} got_t;
    ent_t exp_q[$];
    got_t got_q[$];
    ent_t em;
    got_t gm;

    mul_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    mul_share_arbiter #(
        .N_REQ(4), .ID_W(2)
`ifdef MUL_WATCHDOG_EN
        , .TIMEOUT(TOUT)
`endif
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_do(mul_do),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus.req_valid = valid;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[32*i +: 32] = opa[i];
            bus.req_b[32*i +: 32] = opb[i];
        end
    end

    // multiplier model: done after lat cycles of mul_do, suppressible by hold
    always @(posedge clk) mcnt <= mul_do ? mcnt + 1 : 0;
    assign mul_done = (mul_do && !hold && mcnt >= lat - 1) || spur;
    assign mul_result = 64'(mul_a) * 64'(mul_b);

    // accept -> expected entry from the driven operands; response -> observed entry
    always @(negedge clk) if (reset) begin
        if (bus.req_ready != 0) begin
            em.id = 0;
            for (int i = 0; i < 4; i++) if (bus.req_ready[i]) em.id = i;
            em.err = wd_exp;
            em.res = wd_exp ? 64'd0 : 64'(opa[em.id]) * 64'(opb[em.id]);
            em.cyc = cyc;
            em.dly = wd_exp ? TOUT + 1 : lat + 1;
            em.chk = chk_dly;
            exp_q.push_back(em);
        end
        if (bus.rsp_valid != 0) begin
            gm.v = bus.rsp_valid; gm.id = bus.rsp_id; gm.res = bus.rsp_result;
            gm.err = bus.rsp_err; gm.cyc = cyc;
            got_q.push_back(gm);
        end
    end

    task automatic pulse_reset();
        valid = '0; hold = 0; spur = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({busy, mul_do, mul_a, mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.req_ready} !== '0) begin
            errs++;
            $display("FAIL reset_values got %h want 0", {busy, mul_do, mul_a, mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, bus.req_ready});
        end
        @(posedge clk); #1 reset = 1;
    endtask

    task automatic test_single();
        ent_t e; got_t g;
        @(posedge clk); #1;
        opa[2] = 32'hFFFFFFFF; opb[2] = 32'hFFFFFFFF; valid = 4'b0100;
        #1 vectors++;
        if (bus.req_ready !== 4'b0100) begin errs++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
        @(posedge clk); #1 valid = '0;
        vectors++;
        if ({bus.req_ready, mul_do, busy, mul_a, mul_b} !== {4'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin
            errs++; $display("FAIL single_busy got %h", {bus.req_ready, mul_do, busy, mul_a, mul_b});
        end
        for (int t = 0; t < 100 && got_q.size() < 1; t++) @(posedge clk);
        vectors++;
        if (got_q.size() < 1) begin errs++; $display("FAIL single_timeout got 0 responses want 1"); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b1 << e.id, 2'(e.id), e.res, e.err} || g.res !== 64'hFFFFFFFE00000001) begin
                errs++; $display("FAIL single_rsp got v=%b id=%0d r=%h e=%b want id=%0d r=fffffffe00000001", g.v, g.id, g.res, g.err, e.id);
            end
            vectors++;
            if (g.cyc - e.cyc !== e.dly) begin errs++; $display("FAIL single_latency got %0d want %0d", g.cyc - e.cyc, e.dly); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        ent_t e; got_t g; int k = 0;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin opa[i] = i + 1; opb[i] = 10; end
        valid = 4'hF;
        for (int t = 0; t < 300 && got_q.size() < 6; t++) @(posedge clk);
        #1 valid = '0;
        for (int t = 0; t < 100 && (busy || exp_q.size() != got_q.size()); t++) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() < 6 || exp_q.size() != got_q.size()) begin
            errs++; $display("FAIL contention_count got %0d/%0d want >=6 equal", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b1 << e.id, 2'(e.id), e.res, e.err} || g.id !== 2'(k % 4) || g.res !== 64'((k % 4 + 1) * 10)) begin
                errs++; $display("FAIL contention_rsp[%0d] got id=%0d r=%0d want id=%0d r=%0d", k, g.id, g.res, k % 4, (k % 4 + 1) * 10);
            end
            vectors++;
            if (g.cyc - e.cyc !== e.dly) begin errs++; $display("FAIL contention_latency got %0d want %0d", g.cyc - e.cyc, e.dly); end
            k++;
        end
    endtask

    task automatic test_starvation();
        ent_t e; got_t g; int k = 0;
        pulse_reset();
        opa[0] = $urandom; opb[0] = $urandom; opa[3] = $urandom; opb[3] = $urandom;
        valid = 4'b1001;
        for (int t = 0; t < 300 && got_q.size() < 6; t++) @(posedge clk);
        #1 valid = '0;
        for (int t = 0; t < 100 && (busy || exp_q.size() != got_q.size()); t++) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() < 6) begin errs++; $display("FAIL starve_count got %0d want >=6", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b1 << e.id, 2'(e.id), e.res, e.err} || g.id !== ((k % 2) ? 2'd3 : 2'd0)) begin
                errs++; $display("FAIL starve_rsp[%0d] got id=%0d r=%h want id=%0d r=%h", k, g.id, g.res, (k % 2) ? 3 : 0, e.res);
            end
            k++;
        end
    endtask

    task automatic test_reset_busy();
        ent_t e; got_t g;
        pulse_reset();
        opa[1] = $urandom; opb[1] = $urandom; opa[3] = $urandom; opb[3] = $urandom;
        valid = 4'b0010;
        @(posedge clk); #1 valid = '0;
        for (int t = 0; t < 100 && (busy || got_q.size() < 1); t++) begin @(posedge clk); #1; end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b0010, 2'd1, e.res, 1'b0}) begin
                errs++; $display("FAIL rstb_first got v=%b id=%0d r=%h want v=0010 id=1 r=%h", g.v, g.id, g.res, e.res);
            end
        end
        valid = 4'b1010;
        #1 vectors++;
        if (bus.req_ready !== 4'b1000) begin errs++; $display("FAIL rstb_rr_ready got %b want 1000", bus.req_ready); end
        @(posedge clk); #1;
        vectors++;
        if (mul_do !== 1'b1) begin errs++; $display("FAIL rstb_mul_do got %b want 1", mul_do); end
        #2 reset = 0;
        #1 vectors++;
        if ({busy, mul_do, mul_a, mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err} !== '0) begin
            errs++; $display("FAIL rstb_values got %h want 0", {busy, mul_do, mul_a, mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err});
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1 vectors++;
        if (bus.req_ready !== 4'b0010) begin errs++; $display("FAIL rstb_ptr_ready got %b want 0010", bus.req_ready); end
        @(posedge clk); #1 valid = '0;
        for (int t = 0; t < 100 && (busy || got_q.size() < 1); t++) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin errs++; $display("FAIL rstb_count got %0d/%0d want 1/1", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b0010, 2'd1, e.res, 1'b0}) begin
                errs++; $display("FAIL rstb_rsp got v=%b id=%0d r=%h want v=0010 id=1 r=%h", g.v, g.id, g.res, e.res);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_spurious_done();
        ent_t e; got_t g;
        @(posedge clk); #1 spur = 1;
        @(posedge clk); #1 spur = 0;
        repeat (3) @(posedge clk);
        #1 vectors++;
        if ({busy, mul_do, bus.rsp_valid} !== 6'b0 || got_q.size() != 0) begin
            errs++; $display("FAIL spurious got busy=%b do=%b v=%b n=%0d want 0", busy, mul_do, bus.rsp_valid, got_q.size());
        end
        opa[2] = $urandom; opb[2] = $urandom; valid = 4'b0100;
        @(posedge clk); #1 valid = '0;
        for (int t = 0; t < 100 && (busy || got_q.size() < 1); t++) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin errs++; $display("FAIL spurious_count got %0d/%0d want 1/1", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b1 << e.id, 2'(e.id), e.res, e.err} || g.cyc - e.cyc !== e.dly) begin
                errs++; $display("FAIL spurious_rsp got id=%0d r=%h dly=%0d want id=%0d r=%h dly=%0d", g.id, g.res, g.cyc - e.cyc, e.id, e.res, e.dly);
            end
        end
    endtask

    task automatic test_watchdog();
        ent_t e; got_t g; int bad = 0;
        pulse_reset();
        hold = 1;
`ifdef MUL_WATCHDOG_EN
        wd_exp = 1; chk_dly = 1;
`else
        wd_exp = 0; chk_dly = 0;
`endif
        opa[0] = $urandom; opb[0] = $urandom; valid = 4'b0001;
        @(posedge clk); #1 valid = '0;
`ifndef MUL_WATCHDOG_EN
        for (int t = 0; t < 40; t++) begin
            if (busy !== 1'b1 || mul_do !== 1'b1 || bus.rsp_valid !== 4'b0) bad++;
            @(posedge clk); #1;
        end
        vectors++;
        if (bad != 0) begin errs++; $display("FAIL nowd_hold got %0d bad cycles want 0", bad); end
        hold = 0;
`endif
        for (int t = 0; t < 100 && (busy || got_q.size() < 1); t++) begin @(posedge clk); #1; end
        vectors++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin errs++; $display("FAIL wd_count got %0d/%0d want 1/1", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if ({g.v, g.id, g.res, g.err} !== {4'b0001, 2'd0, e.res, e.err}) begin
                errs++; $display("FAIL wd_rsp got v=%b r=%h e=%b want v=0001 r=%h e=%b", g.v, g.res, g.err, e.res, e.err);
            end
            vectors++;
            if (e.chk && g.cyc - e.cyc !== e.dly) begin errs++; $display("FAIL wd_latency got %0d want %0d", g.cyc - e.cyc, e.dly); end
        end
        vectors++;
        if (bus.rsp_err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL wd_after got err=%b busy=%b want 0 0", bus.rsp_err, busy); end
        hold = 0; wd_exp = 0; chk_dly = 1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end
        test_reset();
        test_single();
        test_contention();
        test_starvation();
        test_reset_busy();
        test_spurious_done();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
